// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled
//   8N1 UART receiver clocked entirely from the system clock. The RX pin is
//   brought in through a two-flop synchronizer, the start bit is qualified
//   at its midpoint, and every following bit is sampled one bit period later
//   (i.e. at mid-bit). Received bytes are handed over with a valid/ack
//   handshake plus framing-error pulse and sticky overrun flag.
//
//   CLKS_PER_BIT must be >= 4.
//
// Ports
//   clk           in   system clock
//   reset         in   synchronous, active-high reset
//   RsRx          in   asynchronous serial input, idle high
//   RX_Ack        in   consumer acknowledges RX_Data, clears RX_Valid
//   RX_Data       out  last good received byte (LSB first on the wire)
//   RX_Valid      out  high from byte completion until RX_Ack
//   RX_Frame_Err  out  one-cycle pulse when the stop bit is sampled low
//   RX_Overrun    out  sticky: good byte landed while RX_Valid was high
//   RX_Busy       out  high whenever the receiver is not idle
//
// State table
//   S_IDLE  | line idle, waiting for a low level on rx_s
//   S_START | timing to the middle of the start bit, glitch check
//   S_DATA  | sampling the 8 data bits, one per bit period
//   S_STOP  | sampling the stop bit, deliver byte or flag framing error
//   S_BREAK | line held low after a framing error, wait for it to go high
module uart_rx_oversampled #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RsRx,
    input  logic       RX_Ack,
    output logic [7:0] RX_Data,
    output logic       RX_Valid,
    output logic       RX_Frame_Err,
    output logic       RX_Overrun,
    output logic       RX_Busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_TC  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state_q;
    logic             sync_q;
    logic             rx_s_q;
    logic [CNT_W-1:0] cyc_cnt_q;
    logic [CNT_W-1:0] cyc_cnt_d;
    logic [2:0]       idx_q;
    logic [7:0]       shift_q;
    logic [7:0]       data_q;
    logic             valid_q;
    logic             frame_err_q;
    logic             overrun_q;
    logic             busy_q;
    logic             good_done;

    assign cyc_cnt_d = cyc_cnt_q + 1'b1;

    // Stop bit sampled high this cycle: the byte is delivered on this edge.
    assign good_done = (state_q == S_STOP) && (cyc_cnt_q == BIT_TC) && rx_s_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 1'b1;
            rx_s_q <= 1'b1;
        end else begin
            sync_q <= RsRx;
            rx_s_q <= sync_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cyc_cnt_q   <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;

            // A completing byte takes priority over an ack in the same cycle;
            // the ack then only suppresses a new overrun, it does not clear one.
            if (good_done) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
                if (valid_q && !RX_Ack) begin
                    overrun_q <= 1'b1;
                end
            end else if (RX_Ack && valid_q) begin
                valid_q   <= 1'b0;
                overrun_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_q   <= S_START;
                        cyc_cnt_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end

                S_START: begin
                    if (cyc_cnt_q == HALF_TC) begin
                        cyc_cnt_q <= '0;
                        if (!rx_s_q) begin
                            state_q <= S_DATA;
                            idx_q   <= '0;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cyc_cnt_q <= cyc_cnt_d;
                    end
                end

                S_DATA: begin
                    if (cyc_cnt_q == BIT_TC) begin
                        cyc_cnt_q      <= '0;
                        shift_q[idx_q] <= rx_s_q;
                        if (idx_q == 3'd7) begin
                            state_q <= S_STOP;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else begin
                        cyc_cnt_q <= cyc_cnt_d;
                    end
                end

                S_STOP: begin
                    if (cyc_cnt_q == BIT_TC) begin
                        cyc_cnt_q <= '0;
                        if (rx_s_q) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_BREAK;
                        end
                    end else begin
                        cyc_cnt_q <= cyc_cnt_d;
                    end
                end

                S_BREAK: begin
                    // A held-low line must go high before a new start is accepted.
                    if (rx_s_q) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign RX_Data      = data_q;
    assign RX_Valid     = valid_q;
    assign RX_Frame_Err = frame_err_q;
    assign RX_Overrun   = overrun_q;
    assign RX_Busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Testbench for uart_rx_oversampled: drives 8N1 frames at 868 clk/bit and
// scoreboards every RX_Valid rise / RX_Frame_Err pulse against the byte,
// kind and clock cycle predicted from the frame start.
module tb_uart_rx_oversampled;

    localparam int CPB = 868;
    // Cycles from the start-bit drive to the first cycle the result is visible:
    // 2 synchronizer flops + IDLE detect, half a bit to the start midpoint,
    // then nine full bits to the stop-bit midpoint.
    localparam int DONE_OFS = 3 + CPB / 2 + 9 * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       RsRx = 1'b1;
    logic       RX_Ack = 1'b0;
    logic [7:0] RX_Data;
    logic       RX_Valid;
    logic       RX_Frame_Err;
    logic       RX_Overrun;
    logic       RX_Busy;

    uart_rx_oversampled #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .reset        (reset),
        .RsRx         (RsRx),
        .RX_Ack       (RX_Ack),
        .RX_Data      (RX_Data),
        .RX_Valid     (RX_Valid),
        .RX_Frame_Err (RX_Frame_Err),
        .RX_Overrun   (RX_Overrun),
        .RX_Busy      (RX_Busy)
    );

    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         at_cyc;
    } ev_t;

    ev_t exp_q[$];

    // Reference model of the receiver's visible outputs
    bit         m_valid = 1'b0;
    bit         m_ovr = 1'b0;
    logic [7:0] m_data = 8'h00;

    bit mon_en = 1'b0;
    logic prev_valid = 1'b0;
    logic prev_ferr = 1'b0;
    ev_t  mon_ev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input bit exp_busy);
        chk({tag, "_valid"}, 32'(RX_Valid), 32'(m_valid));
        chk({tag, "_data"}, 32'(RX_Data), 32'(m_data));
        chk({tag, "_overrun"}, 32'(RX_Overrun), 32'(m_ovr));
        chk({tag, "_frame_err"}, 32'(RX_Frame_Err), 32'd0);
        chk({tag, "_busy"}, 32'(RX_Busy), 32'(exp_busy));
    endtask

    // Monitor: every valid rise or framing pulse must match the next expected event.
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_ferr === 1'b1) begin
                chk("ferr_pulse_width", 32'(RX_Frame_Err), 32'd0);
            end
            if ((RX_Valid === 1'b1 && prev_valid !== 1'b1) || RX_Frame_Err === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_event valid=%b ferr=%b data=%h cyc=%0d",
                             RX_Valid, RX_Frame_Err, RX_Data, cyc_n);
                end else begin
                    mon_ev = exp_q.pop_front();
                    chk("sb_event_kind_ferr", 32'(RX_Frame_Err), 32'(mon_ev.is_err));
                    chk("sb_event_cycle", 32'(cyc_n), 32'(mon_ev.at_cyc));
                    if (!mon_ev.is_err) begin
                        chk("sb_event_data", 32'(RX_Data), 32'(mon_ev.data));
                    end
                end
            end
        end
        prev_valid <= RX_Valid;
        prev_ferr  <= RX_Frame_Err;
    end

    // Send one frame; optionally raise RX_Ack in exactly the completion cycle.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit ack_race);
        int  n0;
        ev_t ev;
        repeat ($urandom_range(1, 12)) @(negedge clk);
        RsRx = 1'b0;
        n0 = cyc_n;
        if (!stop_ok || !m_valid) begin
            ev.is_err = !stop_ok;
            ev.data   = b;
            ev.at_cyc = n0 + DONE_OFS;
            exp_q.push_back(ev);
        end
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RsRx = b[i];
            repeat (CPB) @(negedge clk);
        end
        RsRx = stop_ok;
        for (int k = 0; k < CPB; k++) begin
            RX_Ack = ack_race && (cyc_n == n0 + DONE_OFS - 1);
            @(negedge clk);
        end
        RX_Ack = 1'b0;
        if (stop_ok) begin
            if (m_valid && !ack_race) m_ovr = 1'b1;
            m_data  = b;
            m_valid = 1'b1;
        end
    endtask

    task automatic do_ack(input string tag);
        repeat ($urandom_range(1, 20)) @(negedge clk);
        RX_Ack = 1'b1;
        @(negedge clk);
        RX_Ack = 1'b0;
        if (m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
        chk({tag, "_valid"}, 32'(RX_Valid), 32'(m_valid));
        chk({tag, "_overrun"}, 32'(RX_Overrun), 32'(m_ovr));
        chk({tag, "_data"}, 32'(RX_Data), 32'(m_data));
    endtask

    task automatic glitch(input string tag, input int len);
        @(negedge clk);
        RsRx = 1'b0;
        repeat (10) @(negedge clk);
        chk({tag, "_busy_during"}, 32'(RX_Busy), 32'd1);
        repeat (len - 10) @(negedge clk);
        RsRx = 1'b1;
        repeat (CPB / 2 + 10) @(negedge clk);
        check_all(tag, 1'b0);
    endtask

    initial begin
        int quiet_bad;

        // T1: reset hold, then 20 idle bit times with nothing happening
        reset = 1'b1;
        RsRx  = 1'b1;
        repeat (4) @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;
        check_all("t1_reset", 1'b0);
        quiet_bad = 0;
        repeat (20 * CPB) begin
            @(negedge clk);
            if (RX_Busy !== 1'b0 || RX_Valid !== 1'b0 || RX_Frame_Err !== 1'b0 ||
                RX_Overrun !== 1'b0 || RX_Data !== 8'h00) quiet_bad++;
        end
        chk("t1_no_activity", 32'(quiet_bad), 32'd0);

        // T2: single good byte, ack, then an ignored ack
        send_frame(8'hA5, 1'b1, 1'b0);
        check_all("t2_byte", 1'b0);
        do_ack("t2_ack");
        do_ack("t2_ack_idle");

        // T3: back-to-back without ack -> overrun, newer data kept
        send_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'hC3, 1'b1, 1'b0);
        check_all("t3_overrun", 1'b0);
        do_ack("t3_ack");

        // T6a: reset during data bit 4 of 0xFF
        @(negedge clk);
        RsRx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            RsRx = 1'b1;
            repeat (CPB) @(negedge clk);
        end
        RsRx = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        chk("t6_busy_mid_frame", 32'(RX_Busy), 32'd1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_data  = 8'h00;
        check_all("t6_reset", 1'b0);
        repeat (CPB) @(negedge clk);
        check_all("t6_idle_after", 1'b0);

        // T4: framing error, held break, release, then a good byte
        send_frame(8'h55, 1'b0, 1'b0);
        repeat (3 * CPB) @(negedge clk);
        check_all("t4_break", 1'b1);
        RsRx = 1'b1;
        repeat (8) @(negedge clk);
        check_all("t4_release", 1'b0);
        send_frame(8'h0F, 1'b1, 1'b0);
        check_all("t4_good", 1'b0);

        // T6b: ack coincident with completion of 0x81 while 0x0F is still valid
        send_frame(8'h81, 1'b1, 1'b1);
        check_all("t6_ack_race", 1'b0);
        do_ack("t6_ack");

        // T5: start-bit glitches shorter than half a bit
        glitch("t5_glitch100", 100);
        glitch("t5_glitch_rand", $urandom_range(20, CPB / 2 - 40));

        repeat (20) @(negedge clk);
        chk("sb_pending_events", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
